// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit CPU: opcodes, one-hot op indices,
// condition codes, decode-stage states and jump resolution.
package cpu_isa_pkg;

    localparam logic [3:0] OPC_LOAD  = 4'b0000;
    localparam logic [3:0] OPC_AND   = 4'b0001;
    localparam logic [3:0] OPC_ADD   = 4'b0100;
    localparam logic [3:0] OPC_SUB   = 4'b0110;
    localparam logic [3:0] OPC_JUMP  = 4'b1000;
    localparam logic [3:0] OPC_JCOND = 4'b1001;
    localparam logic [3:0] OPC_IN    = 4'b1010;
    localparam logic [3:0] OPC_OUT   = 4'b1110;
    localparam logic [3:0] OPC_EXT   = 4'b1111;

    localparam int unsigned OP_W = 9;

    typedef enum logic [3:0] {
        OPI_LOAD    = 4'd0,
        OPI_AND     = 4'd1,
        OPI_ADD     = 4'd2,
        OPI_SUB     = 4'd3,
        OPI_JUMP    = 4'd4,
        OPI_JCOND   = 4'd5,
        OPI_IN      = 4'd6,
        OPI_OUT     = 4'd7,
        OPI_ILLEGAL = 4'd8
    } op_idx_e;

    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_OPND
    } dec_state_e;

    function automatic logic resolve_taken(input logic [OP_W-1:0] op,
                                           input logic [1:0]      cond,
                                           input logic            z,
                                           input logic            c);
        logic t;
        t = 1'b0;
        if (op[OPI_JUMP]) begin
            t = 1'b1;
        end else if (op[OPI_JCOND]) begin
            case (cond)
                COND_Z:  t = z;
                COND_NZ: t = !z;
                COND_C:  t = c;
                default: t = !c;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: one-hot op vector (ILLEGAL for unknown
// opcodes and for the EXT prefix itself) plus an EXT-prefix flag.
module op_classify
    import cpu_isa_pkg::*;
(
    input  logic [3:0]      opcode,
    output logic [OP_W-1:0] op_onehot,
    output logic            is_ext
);

    always_comb begin
        op_onehot = '0;
        is_ext    = 1'b0;
        case (opcode)
            OPC_LOAD:  op_onehot[OPI_LOAD]  = 1'b1;
            OPC_AND:   op_onehot[OPI_AND]   = 1'b1;
            OPC_ADD:   op_onehot[OPI_ADD]   = 1'b1;
            OPC_SUB:   op_onehot[OPI_SUB]   = 1'b1;
            OPC_JUMP:  op_onehot[OPI_JUMP]  = 1'b1;
            OPC_JCOND: op_onehot[OPI_JCOND] = 1'b1;
            OPC_IN:    op_onehot[OPI_IN]    = 1'b1;
            OPC_OUT:   op_onehot[OPI_OUT]   = 1'b1;
            OPC_EXT: begin
                is_ext                  = 1'b1;
                op_onehot[OPI_ILLEGAL]  = 1'b1;
            end
            default:   op_onehot[OPI_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage: valid/ready in and out, one-hot op,
// immediate, condition and branch resolution, optional two-word EXT form.
module instr_decode_stage
    import cpu_isa_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          EXT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_word,
    input  logic              flag_z,
    input  logic              flag_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [1:0]        out_cond,
    output logic              out_taken,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_ext
);

    dec_state_e        state_q, state_d;
    logic [3:0]        inner_op_q, inner_op_d;
    logic [1:0]        inner_cond_q, inner_cond_d;

    logic              out_valid_d;
    logic [OP_W-1:0]   out_op_d;
    logic [1:0]        out_cond_d;
    logic              out_taken_d;
    logic [DATA_W-1:0] out_imm_d;
    logic              out_ext_d;

    logic              accept;
    logic [3:0]        word_opc;
    logic [3:0]        word_inner;
    logic [1:0]        short_cond;
    logic [DATA_W-1:0] short_imm;
    logic [1:0]        ext_cond_field;
    logic [3:0]        cls_opcode;
    logic [OP_W-1:0]   cls_onehot;
    logic              cls_is_ext;

    assign word_opc   = in_word[DATA_W-1 -: 4];
    assign word_inner = in_word[DATA_W-5 -: 4];
    assign short_cond = in_word[DATA_W-5 -: 2];
    assign short_imm  = DATA_W'(in_word[DATA_W-5:0]);

    // A prefix word only has room for condition bits past the inner opcode
    // when DATA_W >= 10; narrower words fall back to the Z condition.
    if (DATA_W >= 10) begin : g_ext_cond
        assign ext_cond_field = in_word[DATA_W-9 -: 2];
    end else begin : g_no_ext_cond
        assign ext_cond_field = COND_Z;
    end

    assign in_ready = rst_n && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // One classifier serves both paths: the latched inner opcode while
    // waiting for an operand, the live opcode otherwise.
    assign cls_opcode = (state_q == ST_WAIT_OPND) ? inner_op_q : word_opc;

    op_classify u_op_classify (
        .opcode    (cls_opcode),
        .op_onehot (cls_onehot),
        .is_ext    (cls_is_ext)
    );

    always_comb begin
        state_d      = state_q;
        inner_op_d   = inner_op_q;
        inner_cond_d = inner_cond_q;
        out_valid_d  = out_valid;
        out_op_d     = out_op;
        out_cond_d   = out_cond;
        out_taken_d  = out_taken;
        out_imm_d    = out_imm;
        out_ext_d    = out_ext;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (state_q == ST_IDLE) begin
                    if (EXT_EN && cls_is_ext) begin
                        state_d      = ST_WAIT_OPND;
                        inner_op_d   = word_inner;
                        inner_cond_d = (word_inner == OPC_JCOND) ? ext_cond_field : COND_Z;
                    end else begin
                        out_valid_d = 1'b1;
                        out_op_d    = cls_onehot;
                        out_cond_d  = cls_onehot[OPI_JCOND] ? short_cond : COND_Z;
                        out_imm_d   = short_imm;
                        out_ext_d   = 1'b0;
                        out_taken_d = resolve_taken(cls_onehot, out_cond_d, flag_z, flag_c);
                    end
                end else begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_op_d    = cls_onehot;
                    out_cond_d  = inner_cond_q;
                    out_imm_d   = in_word;
                    out_ext_d   = 1'b1;
                    out_taken_d = resolve_taken(cls_onehot, inner_cond_q, flag_z, flag_c);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            inner_op_q   <= '0;
            inner_cond_q <= '0;
            out_valid    <= 1'b0;
            out_op       <= '0;
            out_cond     <= '0;
            out_taken    <= 1'b0;
            out_imm      <= '0;
            out_ext      <= 1'b0;
        end else begin
            state_q      <= state_d;
            inner_op_q   <= inner_op_d;
            inner_cond_q <= inner_cond_d;
            out_valid    <= out_valid_d;
            out_op       <= out_op_d;
            out_cond     <= out_cond_d;
            out_taken    <= out_taken_d;
            out_imm      <= out_imm_d;
            out_ext      <= out_ext_d;
        end
    end

endmodule
